// File: rtl/tank_pkg.sv
// Shared constants for the tank demo: 640x480@60 VGA timing, palette and tank heading type.
package tank_pkg;
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] COL_OFF    = 12'h000;
  localparam logic [11:0] COL_BARREL = 12'hFFF;
  localparam logic [11:0] COL_BODY   = 12'h8A2;
  localparam logic [11:0] COL_WALL   = 12'h888;
  localparam logic [11:0] COL_BG     = 12'h040;

  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider plus horizontal/vertical raster counters with combinational syncs.
module vga_timing
  import tank_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int HVIS    = H_VIS,
  parameter int HFP     = H_FP,
  parameter int HSW     = H_SYNC,
  parameter int HBP     = H_BP,
  parameter int VVIS    = V_VIS,
  parameter int VFP     = V_FP,
  parameter int VSW     = V_SYNC,
  parameter int VBP     = V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(HVIS + HFP + HSW + HBP - 1);
  localparam logic [9:0] V_LAST = 10'(VVIS + VFP + VSW + VBP - 1);
  localparam logic [9:0] H_SS   = 10'(HVIS + HFP);
  localparam logic [9:0] H_SE   = 10'(HVIS + HFP + HSW);
  localparam logic [9:0] V_SS   = 10'(VVIS + VFP);
  localparam logic [9:0] V_SE   = 10'(VVIS + VFP + VSW);
  localparam logic [9:0] HV     = 10'(HVIS);
  localparam logic [9:0] VV     = 10'(VVIS);

  logic [DW-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // vcount steps only when the line wraps, so both counters move on the same tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (tick) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  assign hsync_raw = !(hcount >= H_SS && hcount < H_SE);
  assign vsync_raw = !(vcount >= V_SS && vcount < V_SE);
  assign visible   = (hcount < HV) && (vcount < VV);
endmodule

// File: rtl/tank_game_top.sv
// Battle-tank demo top: button synchronisers, once-per-frame tank motion and the pixel colour mux.
module tank_game_top
  import tank_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int TANK_SIZE = 32,
  parameter int WALL_W    = 8,
  parameter int SPEED     = 1,
  parameter int HVIS      = H_VIS,
  parameter int HFP       = H_FP,
  parameter int HSW       = H_SYNC,
  parameter int HBP       = H_BP,
  parameter int VVIS      = V_VIS,
  parameter int VFP       = V_FP,
  parameter int VSW       = V_SYNC,
  parameter int VBP       = V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [3:0] pix_r,
  output logic [3:0] pix_g,
  output logic [3:0] pix_b,
  output logic       hsync,
  output logic       vsync
);
  localparam logic [9:0] X_MIN   = 10'(WALL_W);
  localparam logic [9:0] X_MAX   = 10'(HVIS - WALL_W - TANK_SIZE);
  localparam logic [9:0] Y_MIN   = 10'(WALL_W);
  localparam logic [9:0] Y_MAX   = 10'(VVIS - WALL_W - TANK_SIZE);
  localparam logic [9:0] X_START = 10'((HVIS - TANK_SIZE) / 2);
  localparam logic [9:0] Y_START = 10'((VVIS - TANK_SIZE) / 2);
  localparam logic [9:0] SPD     = 10'(SPEED);
  localparam logic [9:0] TS      = 10'(TANK_SIZE);
  localparam logic [9:0] HALF    = 10'(TANK_SIZE / 2);
  localparam logic [9:0] BHALF   = 10'(TANK_SIZE / 8);
  localparam logic [9:0] WW      = 10'(WALL_W);
  localparam logic [9:0] HV      = 10'(HVIS);
  localparam logic [9:0] VV      = 10'(VVIS);

  logic       tick, hsync_raw, vsync_raw, visible;
  logic [9:0] hcount, vcount;

  vga_timing #(
    .CLK_DIV(CLK_DIV), .HVIS(HVIS), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VVIS(VVIS), .VFP(VFP), .VSW(VSW), .VBP(VBP)
  ) u_timing (
    .clk(clk), .rst(rst), .tick(tick), .hcount(hcount), .vcount(vcount),
    .hsync_raw(hsync_raw), .vsync_raw(vsync_raw), .visible(visible)
  );

  // {up, down, left, right}; bit order doubles as the movement priority
  logic [3:0] btn_meta, btn_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= {up, down, left, right};
      btn_sync <= btn_meta;
    end
  end

  logic [9:0] tank_x, tank_y;
  dir_t       dir;
  logic       frame_update;

  assign frame_update = tick && (hcount == 10'd0) && (vcount == VV);

  // Bounds are compared before subtracting so the unsigned position never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tank_x <= X_START;
      tank_y <= Y_START;
      dir    <= UP;
    end else if (frame_update) begin
      if (btn_sync[3]) begin
        dir    <= UP;
        tank_y <= (tank_y < Y_MIN + SPD) ? Y_MIN : tank_y - SPD;
      end else if (btn_sync[2]) begin
        dir    <= DOWN;
        tank_y <= (tank_y + SPD > Y_MAX) ? Y_MAX : tank_y + SPD;
      end else if (btn_sync[1]) begin
        dir    <= LEFT;
        tank_x <= (tank_x < X_MIN + SPD) ? X_MIN : tank_x - SPD;
      end else if (btn_sync[0]) begin
        dir    <= RIGHT;
        tank_x <= (tank_x + SPD > X_MAX) ? X_MAX : tank_x + SPD;
      end
    end
  end

  logic [9:0]  cx, cy;
  logic        in_body, in_vstrip, in_hstrip, in_barrel, in_wall;
  logic [11:0] colour;

  assign cx = tank_x + HALF;
  assign cy = tank_y + HALF;

  always_comb begin
    in_body   = (hcount >= tank_x) && (hcount < tank_x + TS) &&
                (vcount >= tank_y) && (vcount < tank_y + TS);
    in_vstrip = (hcount >= cx - BHALF) && (hcount < cx + BHALF);
    in_hstrip = (vcount >= cy - BHALF) && (vcount < cy + BHALF);
    in_barrel = 1'b0;
    case (dir)
      UP:      in_barrel = in_vstrip && (vcount >= tank_y) && (vcount < cy);
      DOWN:    in_barrel = in_vstrip && (vcount >= cy) && (vcount < tank_y + TS);
      LEFT:    in_barrel = in_hstrip && (hcount >= tank_x) && (hcount < cx);
      default: in_barrel = in_hstrip && (hcount >= cx) && (hcount < tank_x + TS);
    endcase
    in_wall = (hcount < WW) || (hcount >= HV - WW) || (vcount < WW) || (vcount >= VV - WW);
    colour  = COL_BG;
    if (!visible)       colour = COL_OFF;
    else if (in_barrel) colour = COL_BARREL;
    else if (in_body)   colour = COL_BODY;
    else if (in_wall)   colour = COL_WALL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {pix_r, pix_g, pix_b} <= COL_OFF;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      {pix_r, pix_g, pix_b} <= colour;
      hsync <= hsync_raw;
      vsync <= vsync_raw;
    end
  end
endmodule

// File: tb/tb_tank_game_top.sv
// Scoreboard bench for tank_game_top on a shrunken raster so many frames fit in a short run.
module tb_tank_game_top;
  localparam int DIV = 2, T = 16, W = 2, S = 1;
  localparam int HVIS = 32, HFP = 1, HSW = 2, HBP = 1;
  localparam int VVIS = 28, VFP = 1, VSW = 1, VBP = 1;
  localparam int H_TOT = HVIS + HFP + HSW + HBP;
  localparam int V_TOT = VVIS + VFP + VSW + VBP;
  localparam int BW = T / 4;
  localparam int X_MIN = W, X_MAX = HVIS - W - T, Y_MIN = W, Y_MAX = VVIS - W - T;
  localparam int FRAME_CLK = H_TOT * V_TOT * DIV;
  localparam int M_UP = 0, M_DOWN = 1, M_LEFT = 2, M_RIGHT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [3:0] pix_r, pix_g, pix_b;
  logic hsync, vsync;

  tank_game_top #(
    .CLK_DIV(DIV), .TANK_SIZE(T), .WALL_W(W), .SPEED(S),
    .HVIS(HVIS), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VVIS(VVIS), .VFP(VFP), .VSW(VSW), .VBP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [33:0] exp_q[$];
  int sched[$];

  logic model_on = 1'b0, chk_on = 1'b0;
  int clk_n, mid_cnt, frames_done;
  int m_x, m_y, m_dir;
  logic [3:0] btn_cur;

  task automatic model_reset();
    clk_n = 0; mid_cnt = 0; frames_done = 0;
    m_x = (HVIS - T) / 2; m_y = (VVIS - T) / 2; m_dir = M_UP;
    btn_cur = 4'b0000;
  endtask

  function automatic logic [11:0] colour(int h, int v);
    int cx, cy, hb;
    logic barrel;
    if (h >= HVIS || v >= VVIS) return 12'h000;
    cx = m_x + T / 2; cy = m_y + T / 2; hb = BW / 2;
    case (m_dir)
      M_UP:    barrel = (h >= cx - hb && h < cx + hb && v >= m_y && v < cy);
      M_DOWN:  barrel = (h >= cx - hb && h < cx + hb && v >= cy && v < m_y + T);
      M_LEFT:  barrel = (v >= cy - hb && v < cy + hb && h >= m_x && h < cx);
      default: barrel = (v >= cy - hb && v < cy + hb && h >= cx && h < m_x + T);
    endcase
    if (barrel) return 12'hFFF;
    if (h >= m_x && h < m_x + T && v >= m_y && v < m_y + T) return 12'h8A2;
    if (h < W || h >= HVIS - W || v < W || v >= VVIS - W) return 12'h888;
    return 12'h040;
  endfunction

  // One axis per frame, highest-priority button wins, clamp to the playfield
  task automatic apply_move(input logic [3:0] b);
    if (b[3])      begin m_dir = M_UP;    m_y = (m_y - S < Y_MIN) ? Y_MIN : m_y - S; end
    else if (b[2]) begin m_dir = M_DOWN;  m_y = (m_y + S > Y_MAX) ? Y_MAX : m_y + S; end
    else if (b[1]) begin m_dir = M_LEFT;  m_x = (m_x - S < X_MIN) ? X_MIN : m_x - S; end
    else if (b[0]) begin m_dir = M_RIGHT; m_x = (m_x + S > X_MAX) ? X_MAX : m_x + S; end
  endtask

  // Reference: raster position follows from the clock count since reset release
  initial begin : model
    int p, h, v;
    logic hs, vs;
    forever begin
      @(posedge clk);
      if (model_on) begin
        p = clk_n / DIV;
        h = p % H_TOT;
        v = (p / H_TOT) % V_TOT;
        hs = !(h >= HVIS + HFP && h < HVIS + HFP + HSW);
        vs = !(v >= VVIS + VFP && v < VVIS + VFP + VSW);
        exp_q.push_back({10'(h), 10'(v), colour(h, v), hs, vs});
        if (clk_n % DIV == DIV - 1 && h == 0 && v == VVIS) begin
          apply_move(btn_cur);
          frames_done++;
        end
        if (clk_n % DIV == 0 && h == 0 && v == 2) mid_cnt++;
        clk_n++;
      end
    end
  end

  initial begin : monitor
    logic [33:0] e;
    logic [13:0] got;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        checks++;
        got = {pix_r, pix_g, pix_b, hsync, vsync};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pixel_queue_empty got=%h required=expected entry", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e[13:0]) begin
            failures++;
            $display("FAIL pixel h=%0d v=%0d got rgb=%h hs=%b vs=%b required rgb=%h hs=%b vs=%b",
                     e[33:24], e[23:14], got[13:2], got[1], got[0], e[13:2], e[1], e[0]);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({pix_r, pix_g, pix_b, hsync, vsync} !== 14'b0000_0000_0000_11) begin
      failures++;
      $display("FAIL %s got rgb=%h hs=%b vs=%b required rgb=000 hs=1 vs=1",
               tag, {pix_r, pix_g, pix_b}, hsync, vsync);
    end
  endtask

  // Glitch the buttons well away from the frame update, then settle on the frame's value
  task automatic drive_buttons(input logic [3:0] code);
    for (int i = 0; i < 20; i++) begin
      {up, down, left, right} = 4'($urandom_range(0, 15));
      #20;
    end
    {up, down, left, right} = code;
    btn_cur = code;
  endtask

  task automatic run_sched();
    int guard;
    for (int f = 0; f < sched.size(); f++) begin
      guard = 0;
      while (mid_cnt <= f && guard < 3 * FRAME_CLK) begin
        @(posedge clk);
        guard++;
      end
      checks++;
      if (mid_cnt <= f) begin
        failures++;
        $display("FAIL frame_wait frame=%0d got mid_cnt=%0d required >%0d", f, mid_cnt, f);
        return;
      end
      drive_buttons(4'(sched[f]));
    end
    guard = 0;
    while (frames_done < sched.size() && guard < 3 * FRAME_CLK) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (frames_done < sched.size()) begin
      failures++;
      $display("FAIL update_wait got frames=%0d required %0d", frames_done, sched.size());
    end
  endtask

  task automatic release_reset();
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_on = 1'b1;
    @(posedge clk);
    chk_on = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_reset_outputs("reset_hold");
    end
    release_reset();

    // right into the clamp, left into the clamp, all four at once, then random
    sched.delete();
    repeat (7)  sched.push_back(4'b0001);
    repeat (13) sched.push_back(4'b0010);
    repeat (3)  sched.push_back(4'b1111);
    repeat (3)  sched.push_back($urandom_range(0, 15));
    repeat (2)  sched.push_back(0);
    run_sched();

    // asynchronous reset away from a clock edge, in the middle of a frame
    @(posedge clk);
    #3;
    model_on = 1'b0;
    chk_on = 1'b0;
    rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    {up, down, left, right} = 4'b0000;
    repeat (10) begin
      @(negedge clk);
      check_reset_outputs("reset_mid_frame");
    end
    release_reset();

    sched.delete();
    repeat (3) sched.push_back($urandom_range(0, 15));
    repeat (2) sched.push_back(0);
    run_sched();

    @(posedge clk);
    #1 chk_on = 1'b0;
    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
